lane_fifo: RTL and testbench
============================

Name: lane_fifo

Overview:
- Per-lane elastic buffer placed directly downstream of the 1:2 demux.
- One instance sits on each demux output pair (data_out0/valid_out0 and data_out1/valid_out1).
- It absorbs bursts from the demux and releases words when the consumer asserts rd_enable.
- It reports full, empty, almost-full and almost-empty levels, plus a sticky error flag for overflow and underflow.

Parameters:
- BITNUMBER, 5, data word width; matches the demux data width.
- ADDR_WIDTH, 2, pointer width; DEPTH = 2**ADDR_WIDTH = 4 words.
- ALMOST_FULL_TH, 3, almost_full asserts when count >= this value.
- ALMOST_EMPTY_TH, 1, almost_empty asserts when count <= this value.

Ports:
- clk  input  1  single clock for all state; rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- data_in  input  BITNUMBER  write word, from demux data_outN.
- wr_enable  input  1  push request, from demux valid_outN.
- rd_enable  input  1  pop request from the downstream consumer.
- data_out  output  BITNUMBER  registered read word.
- valid_out  output  1  high for exactly the cycle after an accepted pop.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= ALMOST_FULL_TH.
- almost_empty  output  1  count <= ALMOST_EMPTY_TH.
- error  output  1  sticky overflow/underflow indicator.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, valid_out=0, error=0.
  - Flags take their count==0 values: empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are don't-care and are never observable before being written.
- Reset mid-operation: all stored words are discarded; the first push after release lands at address 0.
- Push accepted when wr_enable=1 and (full=0 or a pop is accepted in the same cycle).
  - On an accepted push: mem[wr_ptr] <= data_in, and wr_ptr increments modulo DEPTH (natural wrap).
- Pop accepted when rd_enable=1 and empty=0.
  - On an accepted pop: data_out <= mem[rd_ptr], valid_out <= 1, and rd_ptr increments modulo DEPTH.
  - Read latency is 1 cycle from the rd_enable edge to data_out/valid_out.
  - A cycle with no accepted pop: valid_out <= 0 and data_out holds its last value.
- No fall-through: a word pushed in cycle N is poppable from cycle N+1 at the earliest.
- count update per edge:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Simultaneous push and pop:
  - When full: both are accepted; count stays at DEPTH.
  - When empty: only the push is accepted; the pop is an underflow.
  - Otherwise: both are accepted.
- Overflow: wr_enable=1, full=1 and no accepted pop.
  - The word is dropped; pointers and count are unchanged.
  - error <= 1.
- Underflow: rd_enable=1 with empty=1.
  - No pointer change; valid_out stays 0.
  - error <= 1.
- error is sticky until reset.
- Flags are pure decodes of the registered count, so they change one edge after the causing push or pop.
- count width is ADDR_WIDTH+1 bits, so the value DEPTH is representable.
- Thresholds must satisfy 0 <= ALMOST_EMPTY_TH < ALMOST_FULL_TH <= DEPTH. This is not checked in RTL.

Decomposition:
- Shared include file holds:
  - BITNUMBER default (5), shared by the demux, this block and the probador.
  - Default ADDR_WIDTH and threshold constants.
- One sub-module: lane_fifo_mem.
  - DEPTH x BITNUMBER register array.
  - Synchronous write port (we, waddr, wdata); asynchronous read port (raddr, rdata).
  - No reset on the array.
- Pointers, count, flags, error and the output register stay in lane_fifo.
- Top-level pairing of the demux with two lane_fifo instances is a separate wrapper and outside this spec.

Test Plan:
- Reset state: hold reset=0 for 2 cycles -> empty=1, almost_empty=1, full=0, almost_full=0, valid_out=0, data_out=0, error=0.
- Basic ordering: push 5, 7, 4, 9 on consecutive cycles, then rd_enable for 4 cycles. Required response:
  - After the last push, full=1 and almost_full=1.
  - data_out reads 5, 7, 4, 9, each with valid_out=1 one cycle after its rd_enable.
  - empty=1 after the final pop.
- Wrap-around: push 3 words, pop 3, then push 3, 1, 6, 2 -> pointers wrap past address 3; pops return 3, 1, 6, 2; error stays 0.
- Full with simultaneous push/pop: fill with 1, 2, 3, 4, then assert wr_enable (data 8) and rd_enable together for 1 cycle. Required response:
  - data_out=1 with valid_out=1.
  - count stays 4 and full stays 1.
  - Later pops return 2, 3, 4, 8.
- Overflow and underflow:
  - Full plus wr_enable (data 9) without rd_enable -> 9 is dropped, error=1 next cycle, contents unchanged.
  - Separately from reset, rd_enable with empty=1 -> error=1 and valid_out=0.
  - error holds 1 until reset=0.
- Reset mid-burst: after pushing 5 and 7, drive reset=0 asynchronously between edges -> flags return to reset values immediately; the next push of 3 and pop return 3 (not 5).

Source files
------------

// File: rtl/lane_fifo_pkg.sv
// Shared constants for the demux lane path: word width and lane FIFO sizing/thresholds.
package lane_fifo_pkg;

    localparam int BITNUMBER_DEF       = 5;
    localparam int ADDR_WIDTH_DEF      = 2;
    localparam int ALMOST_FULL_TH_DEF  = 3;
    localparam int ALMOST_EMPTY_TH_DEF = 1;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/lane_fifo_mem.sv
// Lane FIFO storage: register array with one synchronous write port and one combinational read port.
module lane_fifo_mem
    import lane_fifo_pkg::*;
#(
    parameter int BITNUMBER  = BITNUMBER_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [BITNUMBER-1:0]  wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [BITNUMBER-1:0]  rdata
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    // No reset: a slot is never read before it has been written.
    logic [BITNUMBER-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lane_fifo.sv
// Per-lane elastic buffer behind the 1:2 demux: registered read, level flags, sticky over/underflow error.
module lane_fifo
    import lane_fifo_pkg::*;
#(
    parameter int BITNUMBER       = BITNUMBER_DEF,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int ALMOST_FULL_TH  = ALMOST_FULL_TH_DEF,
    parameter int ALMOST_EMPTY_TH = ALMOST_EMPTY_TH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITNUMBER-1:0] data_in,
    input  logic                 wr_enable,
    input  logic                 rd_enable,
    output logic [BITNUMBER-1:0] data_out,
    output logic                 valid_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(fifo_depth(ADDR_WIDTH));
    localparam logic [CW-1:0] AF_CNT    = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0] AE_CNT    = CW'(ALMOST_EMPTY_TH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [BITNUMBER-1:0]  data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  error_q, error_d;

    logic [BITNUMBER-1:0]  mem_rdata;
    logic                  push_ok, pop_ok, overflow, underflow;

    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign pop_ok    = rd_enable & ~empty;
    assign push_ok   = wr_enable & (~full | pop_ok);
    assign overflow  = wr_enable & full & ~pop_ok;
    assign underflow = rd_enable & empty;

    lane_fifo_mem #(
        .BITNUMBER  (BITNUMBER),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = pop_ok;
        error_d     = error_q | overflow | underflow;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
            data_out_d = mem_rdata;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            error_q     <= error_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign error     = error_q;

endmodule

// File: tb/tb_lane_fifo.sv
// Scoreboard bench for lane_fifo: directed pushes/pops, expected read words queued, monitor compares.
module tb_lane_fifo;

    logic       clk;
    logic       reset;
    logic [4:0] data_in;
    logic       wr_enable;
    logic       rd_enable;
    logic [4:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       error;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    lane_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .wr_enable    (wr_enable),
        .rd_enable    (rd_enable),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every valid_out must match the next queued expected word.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: data_out=%0d, no read was expected", data_out);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (data_out !== 5'(e)) begin
                    errors++;
                    $display("FAIL read_data: data_out=%0d expected=%0d", data_out, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Flags in order: full, empty, almost_full, almost_empty, error.
    task automatic chk_flags(input string name, input int f, input int e, input int af,
                             input int ae, input int er);
        chk({name, ".full"}, int'(full), f);
        chk({name, ".empty"}, int'(empty), e);
        chk({name, ".almost_full"}, int'(almost_full), af);
        chk({name, ".almost_empty"}, int'(almost_empty), ae);
        chk({name, ".error"}, int'(error), er);
    endtask

    // Drive one cycle of inputs from a negedge; exp_rd >= 0 queues the word this pop must return.
    task automatic step(input logic wr, input int d, input logic rd, input int exp_rd);
        wr_enable = wr;
        data_in   = 5'(d);
        rd_enable = rd;
        if (exp_rd >= 0) exp_q.push_back(exp_rd);
        @(negedge clk);
    endtask

    task automatic push(input int d);
        step(1'b1, d, 1'b0, -1);
    endtask

    task automatic pop(input int exp_rd);
        step(1'b0, 0, 1'b1, exp_rd);
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, -1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int basic_v[4] = '{5, 7, 4, 9};
        int wrap_v[4]  = '{3, 1, 6, 2};

        reset     = 1'b0;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        data_in   = '0;
        @(negedge clk);
        @(negedge clk);
        chk_flags("reset", 0, 1, 0, 1, 0);
        chk("reset.valid_out", int'(valid_out), 0);
        chk("reset.data_out", int'(data_out), 0);
        reset = 1'b1;
        idle();

        // Basic ordering
        push(basic_v[0]);
        chk_flags("one_word", 0, 0, 0, 1, 0);
        push(basic_v[1]);
        push(basic_v[2]);
        chk_flags("three_words", 0, 0, 1, 0, 0);
        push(basic_v[3]);
        chk_flags("four_words", 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) pop(basic_v[i]);
        chk_flags("drained", 0, 1, 0, 1, 0);
        idle();

        // Wrap-around: pointers start at 0, move to 3, then wrap through 0..2
        push(10); push(11); push(12);
        pop(10); pop(11); pop(12);
        for (int i = 0; i < 4; i++) push(wrap_v[i]);
        chk_flags("wrap_full", 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) pop(wrap_v[i]);
        chk_flags("wrap_drained", 0, 1, 0, 1, 0);
        idle();

        // Full with simultaneous push and pop
        push(1); push(2); push(3); push(4);
        step(1'b1, 8, 1'b1, 1);
        chk_flags("full_push_pop", 1, 0, 1, 0, 0);
        idle();
        chk("full_push_pop.valid_clears", int'(valid_out), 0);
        chk("full_push_pop.data_holds", int'(data_out), 1);
        pop(2); pop(3); pop(4); pop(8);
        chk_flags("full_push_pop_drained", 0, 1, 0, 1, 0);
        idle();

        // Overflow: 9 is dropped
        push(1); push(2); push(3); push(4);
        push(9);
        chk_flags("overflow", 1, 0, 1, 0, 1);
        pop(1); pop(2); pop(3); pop(4);
        chk_flags("overflow_drained", 0, 1, 0, 1, 1);
        idle();
        chk("overflow.error_sticky", int'(error), 1);

        do_reset();
        chk("after_reset.error", int'(error), 0);

        // Underflow
        step(1'b0, 0, 1'b1, -1);
        chk("underflow.valid_out", int'(valid_out), 0);
        chk_flags("underflow", 0, 1, 0, 1, 1);
        idle();
        idle();
        chk("underflow.error_sticky", int'(error), 1);

        // Reset mid-burst, asserted between edges
        do_reset();
        push(5); push(7);
        chk_flags("mid_burst", 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk_flags("async_reset", 0, 1, 0, 1, 0);
        chk("async_reset.valid_out", int'(valid_out), 0);
        @(negedge clk);
        reset = 1'b1;
        push(3);
        pop(3);
        chk_flags("post_reset_drained", 0, 1, 0, 1, 0);
        idle();
        idle();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
